// File: rtl/seq_div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;

  // The counter must be able to hold DW itself, hence one extra bit.
  function automatic int cnt_width(input int dw);
    return $clog2(dw) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_DW);

endpackage

// File: rtl/seq_div_step.sv
// One combinational radix-2 restoring division iteration.
module seq_div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);

  // rem_in[VW] is zero whenever divisor is nonzero; with a zero divisor the
  // subtraction is a no-op, so keeping it in the compare changes nothing.
  logic [VW+1:0] shifted;
  logic [VW+1:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {2'b00, divisor};
    q_bit   = (shifted >= {2'b00, divisor});
    rem_out = q_bit ? diff[VW:0] : shifted[VW:0];
  end

endmodule

// File: rtl/seq_divider_16x8.sv
// Sequential DW/VW unsigned restoring divider, one quotient bit per enabled clock.
// Optional DIV_BY_ZERO_EN adds div_by_zero and a one-cycle short-circuit for divisor 0.
module seq_divider_16x8
  import seq_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          sclr_n,
  input  logic          clk_ena,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done_tick
`ifdef DIV_BY_ZERO_EN
  ,
  output logic          div_by_zero
`endif
);

  localparam int CW = cnt_width(DW);
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [DW-1:0] dq_reg, dq_next;
  logic [VW-1:0] dvs_reg, dvs_next;
  logic [VW:0]   rem_reg, rem_next;
  logic [DW-1:0] quo_reg, quo_next;
  logic [VW-1:0] remo_reg, remo_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  logic [VW:0]   step_rem;
  logic          step_q;
  logic          accept;
  logic          dbz_hit;

  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

  seq_div_step #(.VW(VW)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (dq_reg[DW-1]),
    .divisor (dvs_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

`ifdef DIV_BY_ZERO_EN
  logic dbz_pend_reg, dbz_pend_next;
  logic dbz_flag_reg, dbz_flag_next;

  assign dbz_hit     = dbz_pend_reg;
  assign div_by_zero = dbz_flag_reg;

  always_comb begin
    dbz_pend_next = dbz_pend_reg;
    dbz_flag_next = dbz_flag_reg;
    if (accept) begin
      dbz_pend_next = (divisor == '0);
      dbz_flag_next = 1'b0;
    end else if ((state_reg == CALC) && dbz_pend_reg) begin
      dbz_pend_next = 1'b0;
      dbz_flag_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      dbz_pend_reg <= 1'b0;
      dbz_flag_reg <= 1'b0;
    end else if (clk_ena) begin
      dbz_pend_reg <= dbz_pend_next;
      dbz_flag_reg <= dbz_flag_next;
    end
  end
`else
  assign dbz_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state_reg <= IDLE;
    end else if (clk_ena) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dq_next    = dq_reg;
    dvs_next   = dvs_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    remo_next  = remo_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          dq_next    = dividend;
          dvs_next   = divisor;
          rem_next   = '0;
          cnt_next   = '0;
          busy_next  = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (dbz_hit) begin
          quo_next   = '1;
          remo_next  = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          // Dividend bits leave at the top while quotient bits enter at the bottom.
          rem_next = step_rem;
          dq_next  = {dq_reg[DW-2:0], step_q};
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == LAST_CNT) begin
            quo_next   = {dq_reg[DW-2:0], step_q};
            remo_next  = step_rem[VW-1:0];
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      cnt_reg  <= '0;
      dq_reg   <= '0;
      dvs_reg  <= '0;
      rem_reg  <= '0;
      quo_reg  <= '0;
      remo_reg <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else if (clk_ena) begin
      cnt_reg  <= cnt_next;
      dq_reg   <= dq_next;
      dvs_reg  <= dvs_next;
      rem_reg  <= rem_next;
      quo_reg  <= quo_next;
      remo_reg <= remo_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  assign quotient  = quo_reg;
  assign remainder = remo_reg;
  assign busy      = busy_reg;
  assign done_tick = done_reg;

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Randomized self-checking bench for seq_divider_16x8 against an arithmetic model.
module tb_seq_divider_16x8;

  logic        clk = 1'b0;
  logic        sclr_n = 1'b0;
  logic        clk_ena = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done_tick;
`ifdef DIV_BY_ZERO_EN
  logic        div_by_zero;
  localparam bit DBZ = 1'b1;
`else
  localparam bit DBZ = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int tab_d[4] = '{1000, 65535, 5, 1234};
  int tab_v[4] = '{7, 255, 200, 0};

  seq_divider_16x8 dut (
    .clk        (clk),
    .sclr_n     (sclr_n),
    .clk_ena    (clk_ena),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done_tick  (done_tick)
`ifdef DIV_BY_ZERO_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected result straight from the arithmetic definition of division.
  task automatic model(input int dvd, input int dvs, output int q, output int r,
                       output int lat, output bit dbz);
    if (dvs == 0) begin
      q   = 16'hFFFF;
      dbz = DBZ;
      r   = DBZ ? 0 : (dvd % 256);
      lat = DBZ ? 1 : 16;
    end else begin
      q   = dvd / dvs;
      r   = dvd % dvs;
      lat = 16;
      dbz = 1'b0;
    end
  endtask

  task automatic accept(input int dvd, input int dvs);
    dividend = dvd[15:0];
    divisor  = dvs[7:0];
    start    = 1'b1;
    tick;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done(input int max, output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (n < max) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick;
      n++;
      if (done_tick === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    sclr_n  = 1'b0;
    clk_ena = 1'b0;
    repeat (3) tick;
    n_checks++;
    if ({quotient, remainder, busy, done_tick} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_state: got q=%0d r=%0d busy=%0b done=%0b, want all 0",
               quotient, remainder, busy, done_tick);
    end
    sclr_n  = 1'b1;
    clk_ena = 1'b1;
    tick;
    $display("reset: q=%0d r=%0d busy=%0b done=%0b", quotient, remainder, busy, done_tick);
  endtask

  task automatic test_directed;
    int q, r, lat, n;
    bit dbz, bok;
    logic [15:0] prev_q;
    for (int i = 0; i < 4; i++) begin
      model(tab_d[i], tab_v[i], q, r, lat, dbz);
      prev_q = quotient;
      accept(tab_d[i], tab_v[i]);
      n_checks++;
      if (quotient !== prev_q) begin
        n_fail++;
        $display("FAIL held_on_accept %0d/%0d: q=%0d want %0d", tab_d[i], tab_v[i], quotient, prev_q);
      end
      wait_done(40, n, bok);
      n_checks++;
      if (n !== lat) begin
        n_fail++;
        $display("FAIL latency %0d/%0d: got %0d want %0d", tab_d[i], tab_v[i], n, lat);
      end
      n_checks++;
      if (quotient !== q[15:0] || remainder !== r[7:0]) begin
        n_fail++;
        $display("FAIL result %0d/%0d: got %0d R%0d want %0d R%0d",
                 tab_d[i], tab_v[i], quotient, remainder, q, r);
      end
      n_checks++;
      if (!bok || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy %0d/%0d: busy_during_calc_ok=%0b busy_at_done=%0b want 1/0",
                 tab_d[i], tab_v[i], bok, busy);
      end
`ifdef DIV_BY_ZERO_EN
      n_checks++;
      if (div_by_zero !== dbz) begin
        n_fail++;
        $display("FAIL div_by_zero %0d/%0d: got %0b want %0b", tab_d[i], tab_v[i], div_by_zero, dbz);
      end
`endif
      tick;
      n_checks++;
      if (done_tick !== 1'b0 || quotient !== q[15:0]) begin
        n_fail++;
        $display("FAIL done_one_cycle %0d/%0d: done=%0b q=%0d want 0 and %0d",
                 tab_d[i], tab_v[i], done_tick, quotient, q);
      end
      $display("directed %0d/%0d -> %0d R%0d latency %0d", tab_d[i], tab_v[i], quotient, remainder, n);
    end
  endtask

  task automatic test_random;
    int dvd, dvs, q, r, lat, n;
    bit dbz, bok;
    for (int i = 0; i < 24; i++) begin
      dvd = int'($urandom_range(0, 65535));
      dvs = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
      model(dvd, dvs, q, r, lat, dbz);
      accept(dvd, dvs);
`ifdef DIV_BY_ZERO_EN
      n_checks++;
      if (div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL dbz_clear_on_accept %0d/%0d: got %0b want 0", dvd, dvs, div_by_zero);
      end
`endif
      wait_done(40, n, bok);
      n_checks++;
      if (n !== lat || quotient !== q[15:0] || remainder !== r[7:0] || !bok) begin
        n_fail++;
        $display("FAIL random %0d/%0d: got %0d R%0d lat %0d busy_ok %0b want %0d R%0d lat %0d busy_ok 1",
                 dvd, dvs, quotient, remainder, n, bok, q, r, lat);
      end
`ifdef DIV_BY_ZERO_EN
      n_checks++;
      if (div_by_zero !== dbz) begin
        n_fail++;
        $display("FAIL random_dbz %0d/%0d: got %0b want %0b", dvd, dvs, div_by_zero, dbz);
      end
`endif
      $display("random %0d/%0d -> %0d R%0d latency %0d", dvd, dvs, quotient, remainder, n);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, n;
    bit bok;
    logic [15:0] prev_q;
    prev_q = quotient;
    accept(1000, 7);
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      clk_ena = !(c >= 6 && c <= 10);
      if (c == 3) begin
        start    = 1'b1;
        dividend = 16'd9999;
        divisor  = 8'd3;
      end else begin
        start = 1'b0;
      end
      if (c == 15) begin
        n_checks++;
        if (quotient !== prev_q) begin
          n_fail++;
          $display("FAIL no_mid_calc_update: q=%0d want %0d", quotient, prev_q);
        end
      end
      tick;
      if (done_tick === 1'b1) begin
        cyc = c;
        break;
      end
    end
    start   = 1'b0;
    clk_ena = 1'b1;
    n_checks++;
    if (cyc !== 21 || quotient !== 16'd142 || remainder !== 8'd6) begin
      n_fail++;
      $display("FAIL stall_ignore 1000/7: done at %0d result %0d R%0d want 21 and 142 R6",
               cyc, quotient, remainder);
    end
    $display("stall 1000/7 -> %0d R%0d done after %0d cycles", quotient, remainder, cyc);

    // Start while in DONE must be accepted like in IDLE.
    accept(300, 10);
    n_checks++;
    if (busy !== 1'b1 || done_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_in_done: busy=%0b done=%0b want 1/0", busy, done_tick);
    end
    wait_done(40, n, bok);
    n_checks++;
    if (n !== 16 || quotient !== 16'd30 || remainder !== 8'd0) begin
      n_fail++;
      $display("FAIL back_to_back 300/10: lat %0d result %0d R%0d want 16 and 30 R0",
               n, quotient, remainder);
    end
    $display("back_to_back 300/10 -> %0d R%0d latency %0d", quotient, remainder, n);

    clk_ena = 1'b0;
    repeat (2) tick;
    n_checks++;
    if (done_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL done_frozen: done=%0b want 1", done_tick);
    end
    clk_ena = 1'b1;
    tick;
    n_checks++;
    if (done_tick !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_release: done=%0b busy=%0b want 0/0", done_tick, busy);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit bok, seen;
    for (int k = 0; k < 2; k++) begin
      accept(1000, 7);
      repeat (8) tick;
      sclr_n  = 1'b0;
      clk_ena = (k == 0);
      tick;
      sclr_n  = 1'b1;
      clk_ena = 1'b1;
      n_checks++;
      if ({quotient, remainder, busy, done_tick} !== 26'd0) begin
        n_fail++;
        $display("FAIL mid_reset ena=%0d: q=%0d r=%0d busy=%0b done=%0b want all 0",
                 1 - k, quotient, remainder, busy, done_tick);
      end
`ifdef DIV_BY_ZERO_EN
      n_checks++;
      if (div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_dbz: got %0b want 0", div_by_zero);
      end
`endif
      seen = 1'b0;
      repeat (20) begin
        tick;
        if (done_tick === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_silent: done/busy seen=%0b want 0", seen);
      end
      accept(100, 3);
      wait_done(40, n, bok);
      n_checks++;
      if (n !== 16 || quotient !== 16'd33 || remainder !== 8'd1) begin
        n_fail++;
        $display("FAIL after_reset 100/3: lat %0d result %0d R%0d want 16 and 33 R1",
                 n, quotient, remainder);
      end
      $display("mid_reset ena=%0d then 100/3 -> %0d R%0d latency %0d", 1 - k, quotient, remainder, n);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
